// File: rtl/position_bram_writer_if.sv
// Record stream and BRAM write port of the position bank writer.
// The slave side is the writer; the master side feeds records and observes writes.
interface position_bram_writer_if;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] in_pos;
    logic [7:0]  in_cell;
    logic        in_last;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [96:0] wr_data;

    modport master (
        output in_valid, in_pos, in_cell, in_last,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_pos, in_cell, in_last,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/position_bram_writer.sv
// Fills the position BRAM bank the ring is not reading with records for this
// cell, then terminates the bank with a null sentinel record.
module position_bram_writer #(
    parameter int DBSIZE = 256,
    parameter int PTR_W  = 9
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  double_buffer,
    input  logic [31:0]           Cell,
    position_bram_writer_if.slave bus,
    output logic [PTR_W-1:0]      count,
    output logic                  done,
    output logic                  overflow
);

    localparam logic [1:0]       ST_IDLE    = 2'd0;
    localparam logic [1:0]       ST_FILL    = 2'd1;
    localparam logic [1:0]       ST_TERM    = 2'd2;
    localparam logic [1:0]       ST_DONE    = 2'd3;
    localparam logic [96:0]      SENTINEL   = {1'b1, 96'd0};
    localparam logic [PTR_W-1:0] LAST_SLOT  = PTR_W'(DBSIZE - 1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [31:0]      BANK1_BASE = 32'(DBSIZE);

    logic [1:0]       state_r,    state_s;
    logic             bank_r,     bank_s;
    logic [PTR_W-1:0] ptr_r,      ptr_s;
    logic             in_ready_r, in_ready_s;
    logic             wr_en_r,    wr_en_s;
    logic [31:0]      wr_addr_r,  wr_addr_s;
    logic [96:0]      wr_data_r,  wr_data_s;
    logic [PTR_W-1:0] count_r,    count_s;
    logic             done_r,     done_s;
    logic             overflow_r, overflow_s;

    logic             xfer_s;
    logic             match_s;
    logic [31:0]      slot_addr_s;
    logic             cell_hi_unused_s;

    assign xfer_s           = bus.in_valid & in_ready_r;
    assign match_s          = (bus.in_cell == Cell[7:0]);
    assign slot_addr_s      = (bank_r ? BANK1_BASE : 32'd0) + {{(32-PTR_W){1'b0}}, ptr_r};
    assign cell_hi_unused_s = ^Cell[31:8];

    // Next-state and next-output computation for the fill sequence.
    always_comb begin
        state_s    = state_r;
        bank_s     = bank_r;
        ptr_s      = ptr_r;
        in_ready_s = in_ready_r;
        wr_en_s    = 1'b0;
        wr_addr_s  = wr_addr_r;
        wr_data_s  = wr_data_r;
        count_s    = count_r;
        done_s     = done_r;
        overflow_s = overflow_r;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s    = ST_FILL;
                    bank_s     = ~double_buffer;
                    ptr_s      = {PTR_W{1'b0}};
                    done_s     = 1'b0;
                    overflow_s = 1'b0;
                    in_ready_s = 1'b1;
                end else begin
                    in_ready_s = 1'b0;
                end
            end
            ST_FILL: begin
                in_ready_s = 1'b1;
                if (xfer_s) begin
                    // The last slot is kept for the sentinel, so a full bank drops.
                    if (match_s && (ptr_r < LAST_SLOT)) begin
                        wr_en_s   = 1'b1;
                        wr_addr_s = slot_addr_s;
                        wr_data_s = {1'b0, bus.in_pos};
                        ptr_s     = ptr_r + PTR_ONE;
                    end else if (match_s) begin
                        overflow_s = 1'b1;
                    end else begin
                        ptr_s = ptr_r;
                    end
                    if (bus.in_last) begin
                        state_s    = ST_TERM;
                        in_ready_s = 1'b0;
                    end else begin
                        state_s = ST_FILL;
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            ST_TERM: begin
                wr_en_s    = 1'b1;
                wr_addr_s  = slot_addr_s;
                wr_data_s  = SENTINEL;
                count_s    = ptr_r;
                done_s     = 1'b1;
                in_ready_s = 1'b0;
                state_s    = ST_DONE;
            end
            default: begin
                state_s    = ST_IDLE;
                in_ready_s = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            bank_r     <= 1'b0;
            ptr_r      <= {PTR_W{1'b0}};
            in_ready_r <= 1'b0;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= 32'd0;
            wr_data_r  <= SENTINEL;
            count_r    <= {PTR_W{1'b0}};
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            bank_r     <= bank_s;
            ptr_r      <= ptr_s;
            in_ready_r <= in_ready_s;
            wr_en_r    <= wr_en_s;
            wr_addr_r  <= wr_addr_s;
            wr_data_r  <= wr_data_s;
            count_r    <= count_s;
            done_r     <= done_s;
            overflow_r <= overflow_s;
        end
    end

    assign bus.in_ready = in_ready_r;
    assign bus.wr_en    = wr_en_r;
    assign bus.wr_addr  = wr_addr_r;
    assign bus.wr_data  = wr_data_r;
    assign count        = count_r;
    assign done         = done_r;
    assign overflow     = overflow_r;

endmodule

// File: tb/tb_position_bram_writer.sv
// Randomized bench for position_bram_writer: each fill's expected write list is
// derived from the accepted records and compared against the captured writes.
module tb_position_bram_writer;

    localparam int          DBSIZE   = 256;
    localparam int          PTR_W    = 9;
    localparam logic [96:0] SENTINEL = {1'b1, 96'd0};

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic             double_buffer;
    logic [31:0]      Cell;
    logic [PTR_W-1:0] count;
    logic             done;
    logic             overflow;

    position_bram_writer_if bus ();

    position_bram_writer #(.DBSIZE(DBSIZE), .PTR_W(PTR_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .double_buffer (double_buffer),
        .Cell          (Cell),
        .bus           (bus.slave),
        .count         (count),
        .done          (done),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          stamp;
        logic [31:0] addr;
        logic [96:0] data;
    } wr_t;

    wr_t act_q[$];
    wr_t exp_q[$];

    // Capture every BRAM write with the clock count at which it became visible.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) act_q.push_back('{cyc, bus.wr_addr, bus.wr_data});
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [95:0] rnd_pos();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    task automatic bus_idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_pos   = 96'd0;
        bus.in_cell  = 8'd0;
    endtask

    task automatic do_fill(input bit db, input logic [7:0] cell_id, input int n,
                           input int match_pct, input int gap_pct, input bit disturb);
        logic [31:0] base;
        logic [95:0] pos;
        logic [7:0]  c;
        int          nelig;
        int          last_t;
        int          ncmp;
        bit          ovf_exp;
        bit          ok;
        Cell          = $urandom();
        Cell[7:0]     = cell_id;
        double_buffer = db;
        base          = db ? 32'd0 : 32'(DBSIZE);
        nelig         = 0;
        ovf_exp       = 1'b0;
        last_t        = 0;
        act_q.delete();
        exp_q.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("ready_rise", bus.in_ready, 1'b1);
        chk("done_clear", done, 1'b0);
        chk("ovf_clear", overflow, 1'b0);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                bus.in_valid = 1'b0;
                bus.in_last  = 1'($urandom());
                bus.in_pos   = rnd_pos();
                bus.in_cell  = cell_id;
                if (disturb) begin
                    double_buffer = ~double_buffer;
                    start         = 1'($urandom());
                end
                @(negedge clk);
                start = 1'b0;
                chk("ready_gap", bus.in_ready, 1'b1);
            end
            pos = rnd_pos();
            c   = ($urandom_range(0, 99) < match_pct) ? cell_id
                                                      : cell_id + 8'($urandom_range(1, 255));
            bus.in_valid = 1'b1;
            bus.in_pos   = pos;
            bus.in_cell  = c;
            bus.in_last  = (i == n - 1);
            chk("ready_fill", bus.in_ready, 1'b1);
            last_t = cyc + 1;
            if (c == cell_id) begin
                if (nelig < DBSIZE - 1) begin
                    exp_q.push_back('{last_t, base + 32'(nelig), {1'b0, pos}});
                    nelig++;
                end else begin
                    ovf_exp = 1'b1;
                end
            end
            @(negedge clk);
        end
        chk("ready_fall", bus.in_ready, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_cell  = cell_id;
        bus.in_last  = 1'b1;
        bus.in_pos   = rnd_pos();
        exp_q.push_back('{last_t + 1, base + 32'(nelig), SENTINEL});
        ok = 1'b0;
        for (int t = 0; t < 8 && !ok; t++) begin
            @(negedge clk);
            bus_idle();
            if (done === 1'b1) ok = 1'b1;
        end
        chk("done_timeout", ok, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        chk("done_hold", done, 1'b1);
        chk("count", count, nelig);
        chk("overflow", overflow, ovf_exp);
        chk("ready_done", bus.in_ready, 1'b0);
        chk("nwrites", act_q.size(), exp_q.size());
        ncmp = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int k = 0; k < ncmp; k++) begin
            chk("wr_stamp", act_q[k].stamp, exp_q[k].stamp);
            chk("wr_addr", act_q[k].addr, exp_q[k].addr);
            chk("wr_data", act_q[k].data, exp_q[k].data);
        end
    endtask

    task automatic reset_mid_fill();
        Cell          = 32'd9;
        double_buffer = 1'($urandom());
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_cell  = 8'd9;
            bus.in_pos   = rnd_pos();
            bus.in_last  = 1'b0;
            @(negedge clk);
        end
        chk("pre_rst_wr", bus.wr_en, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rst_wr_en", bus.wr_en, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_count", count, {PTR_W{1'b0}});
        chk("rst_ready", bus.in_ready, 1'b0);
        chk("rst_addr", bus.wr_addr, 32'd0);
        chk("rst_data", bus.wr_data, SENTINEL);
        bus_idle();
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset_n       = 1'b0;
        start         = 1'b0;
        double_buffer = 1'b0;
        Cell          = 32'd0;
        bus_idle();
        repeat (2) @(negedge clk);
        chk("rst_ready", bus.in_ready, 1'b0);
        chk("rst_wr_en", bus.wr_en, 1'b0);
        chk("rst_addr", bus.wr_addr, 32'd0);
        chk("rst_data", bus.wr_data, SENTINEL);
        chk("rst_count", count, {PTR_W{1'b0}});
        chk("rst_done", done, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", bus.in_ready, 1'b0);

        do_fill(1'b0, 8'd5, 3, 100, 0, 1'b0);
        do_fill(1'b1, 8'd2, 3, 50, 0, 1'b0);
        do_fill(1'b0, 8'd7, 1, 0, 0, 1'b0);
        do_fill(1'b1, 8'd1, DBSIZE + 2, 100, 0, 1'b0);
        do_fill(1'b0, 8'd3, 12, 70, 40, 1'b1);
        reset_mid_fill();
        do_fill(1'($urandom()), 8'd9, 4, 100, 20, 1'b0);
        for (int r = 0; r < 4; r++) begin
            do_fill(1'($urandom()), 8'($urandom()), $urandom_range(1, 24),
                    $urandom_range(20, 100), $urandom_range(0, 50), 1'($urandom()));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/position_bram_writer.md
Name: position_bram_writer

Overview:
- Write-side counterpart of the position ring node's BRAM read path. It fills one cell's position BRAM bank with 97-bit particle records taken from the motion-update stream, then terminates the bank with a null sentinel (bit 96 = 1).
- It always writes the bank the ring is not reading. The ring then consumes that bank after the next double_buffer swap.

Parameters:
- DBSIZE, 256: records per bank. Bank 1 starts at address DBSIZE.
- PTR_W, 9: width of the internal write pointer and of count. Must satisfy 2^PTR_W > DBSIZE.

Ports:
- clk, input, 1: sole clock.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: pulse that begins a new bank fill.
- double_buffer, input, 1: bank the ring currently reads. The writer targets the opposite bank.
- Cell, input, 32: ID of the cell this node owns. Only bits [7:0] are compared.
- in_valid, input, 1: input record valid.
- in_ready, output, 1: writer can accept a record.
- in_pos, input, 96: particle position (x, y, z, 32 bits each).
- in_cell, input, 8: destination cell of the record.
- in_last, input, 1: final record of the stream.
- wr_en, output, 1: BRAM write strobe.
- wr_addr, output, 32: BRAM write address.
- wr_data, output, 97: {null, position}.
- count, output, PTR_W: number of records written in the last completed fill.
- done, output, 1: fill complete, sentinel written.
- overflow, output, 1: sticky; a matching record was dropped because the bank was full.

Behaviour:
- All outputs are registered.
- Reset values: in_ready 0, wr_en 0, wr_addr 0, wr_data {1'b1, 96'b0}, count 0, done 0, overflow 0. State is IDLE, ptr 0, bank 0.
- A record transfers on a rising edge where in_valid and in_ready are both 1.
- States:
  - IDLE: in_ready 0. start moves to FILL.
  - FILL: in_ready 1.
  - TERM: writes the sentinel, one cycle.
  - DONE: done 1, in_ready 0. start moves to FILL.
- Entering FILL:
  - bank latches ~double_buffer; ptr, done and overflow clear.
  - in_ready rises the cycle after start is sampled.
- FILL, accepted record with in_cell == Cell[7:0] and ptr < DBSIZE-1:
  - Next cycle: wr_en 1, wr_addr = ptr + (bank ? DBSIZE : 0), zero-extended to 32 bits, wr_data = {1'b0, in_pos}.
  - ptr increments. Write latency is 1 cycle.
- FILL, accepted record with in_cell != Cell[7:0]: dropped, no write, ptr unchanged.
- FILL, accepted matching record with ptr == DBSIZE-1: dropped, overflow set. Slot DBSIZE-1 is always reserved for the sentinel.
- Cycles in FILL with no transfer: wr_en 0, wr_addr and wr_data hold.
- Accepted record with in_last 1:
  - The record is written if eligible, using the rules above.
  - State moves to TERM; in_ready falls on the next cycle.
  - in_valid and in_last are ignored in that next cycle.
- TERM:
  - wr_en 1, wr_addr = final ptr + bank offset, wr_data = {1'b1, 96'b0}.
  - count = final ptr (sentinel excluded). Then move to DONE.
  - If the last record was written in the TERM-entry cycle, the sentinel write follows it back-to-back.
- start while in FILL or TERM: ignored.
- double_buffer changing mid-fill: ignored, because bank is latched.
- reset_n low at any time: returns immediately to reset values. No sentinel is written, and the partially filled bank is left as is.

Test Plan:
- Fill with double_buffer=0, Cell=5: start, then 3 records with in_cell=5, the third carrying in_last -> writes at addresses 256, 257, 258 with bit 96 = 0, sentinel at 259 = {1, 96'b0}, count=3, done=1.
- Mixed cells with double_buffer=1, Cell=2: records in_cell 2, 7, 2 (last) -> writes at 0 and 1 only, sentinel at 2, count=2.
- Overflow, DBSIZE=4, Cell=1: 5 matching records -> writes at 0..2, overflow=1, sentinel at 3, count=3.
- Empty fill: start, then a single non-matching record with in_last -> only the sentinel at bank base, count=0, done=1.
- Bank latch and handshake: toggle double_buffer mid-fill and hold in_valid with gaps -> addresses stay in the latched bank, no write in gap cycles, each write lands exactly 1 cycle after its transfer.
- Reset mid-fill: assert reset_n=0 after 2 writes -> wr_en=0, done=0, count=0, in_ready=0 immediately. A new start writes from ptr 0.
